// File: rtl/fifo_uart_tx_if.sv
// Read-port handshake between the 8-bit synchronous FIFO and the UART transmitter.
// The transmitter is the master: it issues the pop and consumes the data.
interface fifo_uart_tx_if;
  logic       fifo_rd_en;
  logic       fifo_empty;
  logic [7:0] fifo_data;

  modport master (output fifo_rd_en, input fifo_empty, input fifo_data);
  modport slave  (input fifo_rd_en, output fifo_empty, output fifo_data);
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a synchronous FIFO one byte at a time and sends
// start bit, 8 data bits LSB first, optional parity and 1 or 2 stop bits.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           tx_en,
  fifo_uart_tx_if.master fifo,
  output logic           txd,
  output logic           busy,
  output logic           byte_done
);

  localparam int               CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       STOP_LAST  = 3'(STOP_BITS - 1);
  localparam bit               HAS_PARITY = (PARITY_EN != 0);
  localparam logic             ODD_INV    = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] baud_cnt;
  logic [CNT_W-1:0] baud_cnt_next;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_next;
  logic [7:0]       shift_reg;
  logic [7:0]       shift_next;
  logic             parity_bit;
  logic             parity_next;
  logic             txd_next;
  logic             rd_en_next;
  logic             busy_next;
  logic             done_next;
  logic             bit_end;

  assign bit_end = (baud_cnt == CNT_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The fetch decision is the only point where tx_en and fifo_empty matter;
  // once committed, the frame runs to completion regardless of either.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (tx_en && !fifo.fifo_empty) next_state = FETCH;
      FETCH:   next_state = LOAD;
      LOAD:    next_state = START;
      START:   if (bit_end) next_state = DATA;
      DATA:    if (bit_end && (bit_idx == 3'd7)) next_state = HAS_PARITY ? PARITY : STOP;
      PARITY:  if (bit_end) next_state = STOP;
      STOP:    if (bit_end && (bit_idx == STOP_LAST)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    baud_cnt_next = '0;
    bit_idx_next  = bit_idx;
    shift_next    = shift_reg;
    parity_next   = parity_bit;

    case (state)
      START, DATA, PARITY, STOP: begin
        if (!bit_end && (next_state == state)) baud_cnt_next = baud_cnt + CNT_W'(1);
      end
      default: baud_cnt_next = '0;
    endcase

    // bit_idx counts data bits in DATA and stop bits in STOP, so it restarts on every state entry
    if (next_state != state) begin
      bit_idx_next = '0;
    end else if (bit_end && ((state == DATA) || (state == STOP))) begin
      bit_idx_next = bit_idx + 3'd1;
    end

    if (state == LOAD) begin
      shift_next  = fifo.fifo_data;
      parity_next = ^fifo.fifo_data ^ ODD_INV;
    end else if ((state == DATA) && bit_end) begin
      shift_next = {1'b0, shift_reg[7:1]};
    end
  end

  // Outputs are computed from the upcoming state so they can be registered glitch-free.
  always_comb begin
    txd_next   = 1'b1;
    rd_en_next = (next_state == FETCH);
    busy_next  = (next_state != IDLE);
    done_next  = (state == STOP) && (next_state == IDLE);
    case (next_state)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[0];
      PARITY:  txd_next = parity_next;
      default: txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      baud_cnt        <= '0;
      bit_idx         <= '0;
      shift_reg       <= '0;
      parity_bit      <= 1'b0;
      txd             <= 1'b1;
      fifo.fifo_rd_en <= 1'b0;
      busy            <= 1'b0;
      byte_done       <= 1'b0;
    end else begin
      baud_cnt        <= baud_cnt_next;
      bit_idx         <= bit_idx_next;
      shift_reg       <= shift_next;
      parity_bit      <= parity_next;
      txd             <= txd_next;
      fifo.fifo_rd_en <= rd_en_next;
      busy            <= busy_next;
      byte_done       <= done_next;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench: a FIFO model feeds the transmitter, a line receiver decodes
// each frame and compares it against a scoreboard of expected frames.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  typedef struct {
    logic [7:0]  data;
    logic [11:0] frame;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       tx_en;
  logic [2:0] txd_s;
  logic [2:0] busy_s;
  logic [2:0] done_s;
  logic [2:0] rd_en_s;
  logic [2:0] empty_s;
  logic [7:0] data0 = 8'h00;
  logic [7:0] data1 = 8'h00;
  logic [7:0] data2 = 8'h00;

  logic [7:0]  fifo_mem [64];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic [7:0]  held = 8'h00;
  bit          pend = 1'b0;
  int          underflow = 0;
  int          push_p = 0;
  int          pop1 = 0;
  int          pop2 = 0;
  int          cycle_cnt = 0;
  int          rd_pulses = 0;
  int          assert_count = 0;
  int          fail_count = 0;
  logic [11:0] sb [$];
  vec_t        vecs [8];

  fifo_uart_tx_if bus0 ();
  fifo_uart_tx_if bus1 ();
  fifo_uart_tx_if bus2 ();

  assign empty_s[0]      = (wr_ptr == rd_ptr);
  assign empty_s[1]      = (push_p == pop1);
  assign empty_s[2]      = (push_p == pop2);
  assign bus0.fifo_empty = empty_s[0];
  assign bus1.fifo_empty = empty_s[1];
  assign bus2.fifo_empty = empty_s[2];
  assign bus0.fifo_data  = data0;
  assign bus1.fifo_data  = data1;
  assign bus2.fifo_data  = data2;
  assign rd_en_s[0]      = bus0.fifo_rd_en;
  assign rd_en_s[1]      = bus1.fifo_rd_en;
  assign rd_en_s[2]      = bus2.fifo_rd_en;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clock(clock), .reset_n(reset_n), .tx_en(tx_en), .fifo(bus0.master),
    .txd(txd_s[0]), .busy(busy_s[0]), .byte_done(done_s[0])
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
    .clock(clock), .reset_n(reset_n), .tx_en(tx_en), .fifo(bus1.master),
    .txd(txd_s[1]), .busy(busy_s[1]), .byte_done(done_s[1])
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .tx_en(tx_en), .fifo(bus2.master),
    .txd(txd_s[2]), .busy(busy_s[2]), .byte_done(done_s[2])
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cycle_cnt++;
    if (rd_en_s[0]) rd_pulses++;
  end

  // FIFO model: data of a pop appears one cycle after the rd_en cycle, like the real buffer.
  always @(negedge clock) begin
    if (pend) begin
      data0 = held;
      pend  = 1'b0;
    end
    if (rd_en_s[0]) begin
      if (wr_ptr == rd_ptr) begin
        underflow++;
      end else begin
        held = fifo_mem[rd_ptr];
        rd_ptr++;
        pend = 1'b1;
      end
    end
    if (rd_en_s[1]) begin
      pop1++;
      data1 = 8'h07;
    end
    if (rd_en_s[2]) begin
      pop2++;
      data2 = 8'h07;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before 500000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    fifo_mem[wr_ptr] = v.data;
    wr_ptr++;
    sb.push_back(v.frame);
  endtask

  // Samples each bit in its middle; bit i of frame is the i-th bit on the line.
  task automatic receiveFrame(input int k, input int nbits, output logic [11:0] frame,
                              output int done_at, output int done_cnt, output int fall_at,
                              output logic busy_low);
    frame    = '0;
    done_at  = -1;
    done_cnt = 0;
    fall_at  = -1;
    busy_low = 1'b0;
    for (int w = 0; w < 600; w++) begin
      @(negedge clock);
      if (txd_s[k] == 1'b0) begin
        fall_at = cycle_cnt;
        break;
      end
    end
    if (fall_at < 0) begin
      checkOutput("frame_start_seen", 32'd0, 32'd1);
      return;
    end
    for (int c = 1; c <= nbits * CPB; c++) begin
      @(negedge clock);
      if ((c % CPB) == (CPB / 2)) frame[c / CPB] = txd_s[k];
      if (done_s[k]) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (c == nbits * CPB) busy_low = ~busy_s[k];
    end
  endtask

  initial begin
    logic [11:0] frame;
    logic [11:0] frame_o;
    logic [11:0] exp_frame;
    int          done_at, done_cnt, fall_at, rise_at, prev_fall, pulses_before;
    int          done_at_o, done_cnt_o, fall_at_o;
    logic        busy_low, busy_low_o;
    bit          fall_seen;

    vecs[0] = '{data: 8'hA5, frame: 12'h34A};
    vecs[1] = '{data: 8'h00, frame: 12'h200};
    vecs[2] = '{data: 8'hFF, frame: 12'h3FE};
    vecs[3] = '{data: 8'h3C, frame: 12'h278};
    vecs[4] = '{data: 8'h81, frame: 12'h302};
    vecs[5] = '{data: 8'h42, frame: 12'h284};
    vecs[6] = '{data: 8'h55, frame: 12'h2AA};
    vecs[7] = '{data: 8'hC3, frame: 12'h386};

    reset_n = 1'b0;
    tx_en   = 1'b1;
    applyStimulus(vecs[0]);
    repeat (3) @(negedge clock);
    checkOutput("reset_txd", txd_s[0], 1);
    checkOutput("reset_rd_en", rd_en_s[0], 0);
    checkOutput("reset_busy", busy_s[0], 0);
    checkOutput("reset_byte_done", done_s[0], 0);

    reset_n = 1'b1;
    @(negedge clock);
    rise_at = cycle_cnt;
    checkOutput("release_rd_en_pulse", rd_en_s[0], 1);
    checkOutput("release_busy", busy_s[0], 1);
    @(negedge clock);
    checkOutput("release_rd_en_single", rd_en_s[0], 0);
    receiveFrame(0, 10, frame, done_at, done_cnt, fall_at, busy_low);
    exp_frame = sb.pop_front();
    checkOutput("a5_frame", frame, exp_frame);
    checkOutput("a5_start_latency", fall_at - rise_at, 2);
    checkOutput("a5_byte_done_at", done_at, 40);
    checkOutput("a5_byte_done_count", done_cnt, 1);
    checkOutput("a5_busy_falls_with_done", busy_low, 1);

    pulses_before = rd_pulses;
    for (int i = 1; i <= 3; i++) applyStimulus(vecs[i]);
    prev_fall = -1;
    for (int i = 1; i <= 3; i++) begin
      receiveFrame(0, 10, frame, done_at, done_cnt, fall_at, busy_low);
      exp_frame = sb.pop_front();
      checkOutput($sformatf("b2b_frame_%0d", i), frame, exp_frame);
      checkOutput($sformatf("b2b_byte_done_at_%0d", i), done_at, 40);
      if (i > 1) checkOutput($sformatf("b2b_gap_%0d", i), fall_at - prev_fall, 43);
      prev_fall = fall_at;
    end
    repeat (5) @(negedge clock);
    checkOutput("b2b_rd_en_pulses", rd_pulses - pulses_before, 3);
    checkOutput("b2b_fifo_empty", empty_s[0], 1);
    checkOutput("b2b_busy_idle", busy_s[0], 0);
    checkOutput("b2b_txd_idle", txd_s[0], 1);

    // tx_en drops mid-frame: the frame finishes and the second byte stays queued.
    pulses_before = rd_pulses;
    applyStimulus(vecs[4]);
    applyStimulus(vecs[5]);
    fork
      receiveFrame(0, 10, frame, done_at, done_cnt, fall_at, busy_low);
      begin
        repeat (20) @(negedge clock);
        tx_en = 1'b0;
      end
    join
    exp_frame = sb.pop_front();
    checkOutput("txen_first_frame", frame, exp_frame);
    checkOutput("txen_first_done_at", done_at, 40);
    repeat (12) @(negedge clock);
    checkOutput("txen_no_fetch", rd_pulses - pulses_before, 1);
    checkOutput("txen_idle_busy", busy_s[0], 0);
    checkOutput("txen_idle_txd", txd_s[0], 1);
    tx_en = 1'b1;
    @(negedge clock);
    checkOutput("txen_resume_rd_en", rd_en_s[0], 1);
    receiveFrame(0, 10, frame, done_at, done_cnt, fall_at, busy_low);
    exp_frame = sb.pop_front();
    checkOutput("txen_second_frame", frame, exp_frame);

    // Reset during bit 3 of 0x55 abandons that byte; the next one goes out intact.
    applyStimulus(vecs[6]);
    applyStimulus(vecs[7]);
    fall_seen = 1'b0;
    for (int w = 0; w < 100 && !fall_seen; w++) begin
      @(negedge clock);
      if (txd_s[0] == 1'b0) fall_seen = 1'b1;
    end
    checkOutput("rst_frame_started", fall_seen, 1);
    repeat (17) @(negedge clock);
    checkOutput("rst_bit3_low", txd_s[0], 0);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_async_txd", txd_s[0], 1);
    checkOutput("rst_async_busy", busy_s[0], 0);
    void'(sb.pop_front());
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    receiveFrame(0, 10, frame, done_at, done_cnt, fall_at, busy_low);
    exp_frame = sb.pop_front();
    checkOutput("rst_next_frame", frame, exp_frame);
    checkOutput("rst_next_done_at", done_at, 40);

    // Parity with two stop bits: 0x07 has odd weight, so even parity sends 1 and odd sends 0.
    push_p = 1;
    fork
      receiveFrame(1, 12, frame, done_at, done_cnt, fall_at, busy_low);
      receiveFrame(2, 12, frame_o, done_at_o, done_cnt_o, fall_at_o, busy_low_o);
    join
    checkOutput("parity_even_frame", frame, 12'hE0E);
    checkOutput("parity_even_done_at", done_at, 48);
    checkOutput("parity_even_done_count", done_cnt, 1);
    checkOutput("parity_odd_frame", frame_o, 12'hC0E);
    checkOutput("parity_odd_done_at", done_at_o, 48);
    checkOutput("parity_odd_busy_falls", busy_low_o, 1);

    repeat (5) @(negedge clock);
    checkOutput("fifo_underflow", underflow, 0);
    checkOutput("fifo_drained", wr_ptr - rd_ptr, 0);
    checkOutput("parity_single_pop", pop1 + pop2, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit stage that sits directly downstream of the 8-bit synchronous FIFO and drains it. It pops one byte at a time through the FIFO's read port (`rd_en`, with data valid one cycle later) and serializes the byte onto a UART line. The frame is start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits. The FIFO absorbs producer bursts and this block paces them out at the configured baud rate.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range ≥ 2.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd (only meaningful when `PARITY_EN`=1).
- `STOP_BITS`, 1: number of stop bits; legal values 1 or 2.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `tx_en`  in  1  permits fetching a new byte; sampled only in IDLE.
- `fifo_empty`  in  1  FIFO `buf_empty`.
- `fifo_data`  in  8  FIFO `buf_out`; valid the cycle after a pop.
- `fifo_rd_en`  out  1  FIFO `rd_en`; registered, exactly one cycle per byte.
- `txd`  out  1  serial line; idles high.
- `busy`  out  1  high in every state except IDLE.
- `byte_done`  out  1  one-cycle pulse when the last stop bit of a frame completes.

## Operation
- Reset values (asynchronous, while `reset_n`=0): state=IDLE, `txd`=1, `fifo_rd_en`=0, `busy`=0, `byte_done`=0, baud counter=0, bit index=0, shift register=0.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: on an edge with `tx_en`=1 and `fifo_empty`=0, go to FETCH; otherwise stay. `txd`=1.
- FETCH (1 cycle): `fifo_rd_en`=1; the FIFO pops at the end of this cycle. Next state is LOAD.
- LOAD (1 cycle): `fifo_rd_en`=0. At the end of the cycle, load the shift register from `fifo_data`, compute parity (XOR of the 8 bits; inverted if `PARITY_ODD`), and go to START.
- START: `txd`=0 for `CLKS_PER_BIT` cycles, then DATA.
- DATA: `txd`=shift[0]; shift right every `CLKS_PER_BIT` cycles.
  - After 8 bits, go to PARITY if `PARITY_EN`=1, else to STOP.
- PARITY: `txd`=parity bit for `CLKS_PER_BIT` cycles, then STOP.
- STOP: `txd`=1 for `STOP_BITS`×`CLKS_PER_BIT` cycles.
  - On the final count edge: `byte_done`=1 for the following cycle and the state goes to IDLE.
- Baud counter: counts 0..`CLKS_PER_BIT`-1, clears on every bit boundary and on every state entry. Width is clog2(`CLKS_PER_BIT`). Bit index is 3 bits and never wraps past 7 within a frame.
- `tx_en` deasserted mid-frame: the current frame completes unchanged; no further fetch occurs while `tx_en`=0.
- `fifo_empty` changing during FETCH or LOAD is ignored; the pop was already committed in IDLE.
- A FIFO that empties exactly at frame end leaves the block in IDLE with `txd`=1.
- Reset mid-frame: the line returns to 1 immediately and the frame is abandoned. The byte already popped is lost (accepted behaviour).
- `fifo_rd_en` is never asserted while `fifo_empty`=1 was the value sampled in IDLE.

## Timing
- Edge E0 (IDLE sees the fetch condition) → `fifo_rd_en`=1 during cycle E0..E1.
- `txd` falls at edge E2, i.e. 2 cycles after `fifo_rd_en` rises.
- Frame length from `txd` fall to end of the stop bits: (9 + `PARITY_EN` + `STOP_BITS`)×`CLKS_PER_BIT` cycles.
- Back-to-back frames: exactly 3 extra `txd`-high cycles (IDLE, FETCH, LOAD) between the last stop bit and the next start bit.
- `busy` rises at E0 and falls on the same edge that asserts `byte_done`.

## Test plan
- Reset: hold `reset_n`=0 with `fifo_empty`=0 and `tx_en`=1 → `txd`=1, `fifo_rd_en`=0, `busy`=0, `byte_done`=0. Release → single `fifo_rd_en` pulse on the next edge.
- Single byte, `CLKS_PER_BIT`=4, no parity, 1 stop bit: FIFO holds 0xA5 → `txd` sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. `byte_done` pulses once, 40 cycles after `txd` falls.
- Back-to-back: push 0x00, 0xFF, 0x3C, then hold `tx_en`=1 → three frames, exactly 3 `fifo_rd_en` pulses, 3-cycle high gaps, and `fifo_empty`=1 at the end with `busy`=0.
- Parity and stop bits, `PARITY_EN`=1, `STOP_BITS`=2:
  - Byte 0x07 with `PARITY_ODD`=0 → parity bit 1; frame is 12×`CLKS_PER_BIT` cycles.
  - Byte 0x07 with `PARITY_ODD`=1 → parity bit 0.
- `tx_en` control: drop `tx_en` during DATA of the first of two queued bytes → the first frame completes and the second is not fetched. Raise `tx_en` → the second frame starts with a `fifo_rd_en` pulse on the next edge.
- Reset mid-frame: assert `reset_n`=0 during bit 3 of 0x55 → `txd`=1 asynchronously. After release, the next queued byte transmits correctly from its start bit.
